reg_dump_reader: RTL

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG through a combinational register-file
// read port and streams each captured value out over a valid/ready handshake.
module reg_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rA,
  input  logic [31:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  idx_reg;

  // The read address is the index register itself, so A is valid for a whole READ cycle.
  assign rA = idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_idx   <= 5'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && state_reg != IDLE) begin
      // Cancelling drops the dump outright; a word accepted on this edge still counts.
      state_reg <= IDLE;
      idx_reg   <= 5'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            idx_reg   <= FIRST_IDX;
            busy      <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          out_data  <= A;
          out_idx   <= idx_reg;
          out_last  <= (idx_reg == LAST_IDX);
          out_valid <= 1'b1;
          state_reg <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + 5'd1;
              state_reg <= READ;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
